exec_cc_stage: RTL and testbench

EXEC_CC_STAGE -- requirements
Module: exec_cc_stage

---
 rtl/exec_cc_stage.sv | 177 +++++++++++++++++
 tb/tb_exec_cc_stage.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/exec_cc_stage.sv
// rtl/exec_cc_stage.sv - Y86 execute stage: ALU, condition codes and E->M pipeline register

module exec_cc_ripple_addsub #(
    parameter int W = 64
) (
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    input  logic         mode,
    output logic [W-1:0] sum,
    output logic         overflow
);

    logic [W:0]   carry;
    logic [W-1:0] in2_x;

    assign carry[0] = mode;

    // mode=1 inverts in2 and injects the +1 through the carry-in: in1 - in2.
    for (genvar i = 0; i < W; i++) begin : g_bit
        assign in2_x[i]    = in2[i] ^ mode;
        assign sum[i]      = in1[i] ^ in2_x[i] ^ carry[i];
        assign carry[i+1]  = (in1[i] & in2_x[i]) | (carry[i] & (in1[i] ^ in2_x[i]));
    end

    assign overflow = carry[W] ^ carry[W-1];

endmodule

module exec_cc_stage #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [3:0]   icode,
    input  logic [3:0]   ifun,
    input  logic [W-1:0] valA,
    input  logic [W-1:0] valB,
    input  logic [W-1:0] valC,
    input  logic         stall,
    input  logic         bubble,
    input  logic         set_cc_en,
    output logic         out_valid,
    output logic [3:0]   out_icode,
    output logic [W-1:0] valE,
    output logic         Cnd,
    output logic [2:0]   cc
);

    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RRMOV = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OPQ   = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;

    localparam logic [2:0] CC_RESET = 3'b100;
    localparam logic [W-1:0] STACK_STEP = W'(8);

    logic         out_valid_q, out_valid_d;
    logic [3:0]   out_icode_q, out_icode_d;
    logic [W-1:0] val_e_q, val_e_d;
    logic         cnd_q, cnd_d;
    logic [2:0]   cc_q, cc_d;

    logic [W-1:0] alu_a, alu_b, alu_result, adder_sum;
    logic [3:0]   alu_fun;
    logic         adder_ovf, alu_of;
    logic         zf, sf, of, cond_met;
    logic [2:0]   new_cc;

    always_comb begin
        alu_a = '0;
        unique case (icode)
            I_RRMOV, I_OPQ:          alu_a = valA;
            I_IRMOV, I_RMMOV, I_MRMOV: alu_a = valC;
            I_CALL, I_PUSH:          alu_a = -STACK_STEP;
            I_RET, I_POP:            alu_a = STACK_STEP;
            default:                 alu_a = '0;
        endcase
        alu_b   = (icode == I_IRMOV || icode == I_RRMOV) ? '0 : valB;
        alu_fun = (icode == I_OPQ) ? ifun : F_ADD;
    end

    exec_cc_ripple_addsub #(.W(W)) u_addsub (
        .in1      (alu_b),
        .in2      (alu_a),
        .mode     (alu_fun == F_SUB),
        .sum      (adder_sum),
        .overflow (adder_ovf)
    );

    always_comb begin
        alu_result = '0;
        alu_of     = 1'b0;
        case (alu_fun)
            F_ADD, F_SUB: begin
                alu_result = adder_sum;
                alu_of     = adder_ovf;
            end
            F_AND:   alu_result = alu_b & alu_a;
            F_XOR:   alu_result = alu_b ^ alu_a;
            default: alu_result = '0;
        endcase
        new_cc = {(alu_result == '0), alu_result[W-1], alu_of};
    end

    // Conditions always look at the registered flags, so an OPQ in the
    // previous cycle is already visible to the JXX/CMOV now in execute.
    always_comb begin
        {zf, sf, of} = cc_q;
        cond_met = 1'b0;
        case (ifun)
            4'h0:    cond_met = 1'b1;
            4'h1:    cond_met = (sf ^ of) | zf;
            4'h2:    cond_met = sf ^ of;
            4'h3:    cond_met = zf;
            4'h4:    cond_met = ~zf;
            4'h5:    cond_met = ~(sf ^ of);
            4'h6:    cond_met = ~(sf ^ of) & ~zf;
            default: cond_met = 1'b0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_icode_d = out_icode_q;
        val_e_d     = val_e_q;
        cnd_d       = cnd_q;
        cc_d        = cc_q;
        if (rst) begin
            out_valid_d = 1'b0;
            out_icode_d = I_NOP;
            val_e_d     = '0;
            cnd_d       = 1'b0;
            cc_d        = CC_RESET;
        end else if (bubble || (!stall && !in_valid)) begin
            out_valid_d = 1'b0;
            out_icode_d = I_NOP;
            val_e_d     = '0;
            cnd_d       = 1'b0;
        end else if (!stall) begin
            out_valid_d = 1'b1;
            out_icode_d = icode;
            val_e_d     = alu_result;
            cnd_d       = (icode == I_RRMOV || icode == I_JXX) ? cond_met : 1'b0;
            if (icode == I_OPQ && set_cc_en) begin
                cc_d = new_cc;
            end
        end
    end

    always_ff @(posedge clk) begin
        out_valid_q <= out_valid_d;
        out_icode_q <= out_icode_d;
        val_e_q     <= val_e_d;
        cnd_q       <= cnd_d;
        cc_q        <= cc_d;
    end

    assign out_valid = out_valid_q;
    assign out_icode = out_icode_q;
    assign valE      = val_e_q;
    assign Cnd       = cnd_q;
    assign cc        = cc_q;

endmodule

// File: tb/tb_exec_cc_stage.sv
// tb/tb_exec_cc_stage.sv - self-checking bench for exec_cc_stage against a behavioural model

module tb_exec_cc_stage;

    localparam int W = 64;

    logic         clk = 1'b0;
    logic         rst, in_valid, stall, bubble, set_cc_en;
    logic [3:0]   icode, ifun;
    logic [W-1:0] valA, valB, valC;
    logic         out_valid, Cnd;
    logic [3:0]   out_icode;
    logic [W-1:0] valE;
    logic [2:0]   cc;

    int checks = 0;
    int errors = 0;

    exec_cc_stage #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .icode     (icode),
        .ifun      (ifun),
        .valA      (valA),
        .valB      (valB),
        .valC      (valC),
        .stall     (stall),
        .bubble    (bubble),
        .set_cc_en (set_cc_en),
        .out_valid (out_valid),
        .out_icode (out_icode),
        .valE      (valE),
        .Cnd       (Cnd),
        .cc        (cc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the stage's observable state written in plain arithmetic.
    logic         m_ready = 1'b0;
    logic         m_valid;
    logic [3:0]   m_icode;
    logic [63:0]  m_vale;
    logic         m_cnd;
    logic [2:0]   m_cc;

    function automatic logic cond_of(input logic [3:0] fn, input logic [2:0] flags);
        logic z, s, o;
        {z, s, o} = flags;
        case (fn)
            4'h0: return 1'b1;
            4'h1: return (s != o) || z;
            4'h2: return s != o;
            4'h3: return z;
            4'h4: return !z;
            4'h5: return s == o;
            4'h6: return (s == o) && !z;
            default: return 1'b0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [63:0] a, b, r;
        logic        o;
        logic [3:0]  fn;
        if (rst) begin
            m_ready <= 1'b1;
            m_valid <= 1'b0; m_icode <= 4'h1; m_vale <= '0; m_cnd <= 1'b0; m_cc <= 3'b100;
        end else if (bubble || (!stall && !in_valid)) begin
            m_valid <= 1'b0; m_icode <= 4'h1; m_vale <= '0; m_cnd <= 1'b0;
        end else if (!stall) begin
            case (icode)
                4'h2, 4'h6:       a = valA;
                4'h3, 4'h4, 4'h5: a = valC;
                4'h8, 4'hA:       a = 64'd0 - 64'd8;
                4'h9, 4'hB:       a = 64'd8;
                default:          a = 64'd0;
            endcase
            b  = (icode == 4'h2 || icode == 4'h3) ? 64'd0 : valB;
            fn = (icode == 4'h6) ? ifun : 4'h0;
            o  = 1'b0;
            case (fn)
                4'h0: begin r = b + a; o = (a[63] == b[63]) && (r[63] != b[63]); end
                4'h1: begin r = b - a; o = (a[63] != b[63]) && (r[63] != b[63]); end
                4'h2: r = b & a;
                4'h3: r = b ^ a;
                default: r = 64'd0;
            endcase
            m_valid <= 1'b1;
            m_icode <= icode;
            m_vale  <= r;
            m_cnd   <= (icode == 4'h2 || icode == 4'h7) ? cond_of(ifun, m_cc) : 1'b0;
            if (icode == 4'h6 && set_cc_en)
                m_cc <= {(r == 64'd0), r[63], o};
        end
    end

    always @(negedge clk) begin
        if (m_ready) begin
            chk("model_out_valid", out_valid, m_valid);
            chk("model_out_icode", out_icode, m_icode);
            chk("model_valE", valE, m_vale);
            chk("model_Cnd", Cnd, m_cnd);
            chk("model_cc", cc, m_cc);
        end
    end

    // Apply one cycle of inputs just after a falling edge and return at the next one.
    task automatic step(input logic r, input logic v, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                        input logic st, input logic bb, input logic en);
        rst = r; in_valid = v; icode = ic; ifun = fn;
        valA = a; valB = b; valC = c;
        stall = st; bubble = bb; set_cc_en = en;
        @(negedge clk);
    endtask

    function automatic logic [63:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 64'h0;
            1: return 64'h7FFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'hFFFF_FFFF_FFFF_FFFF;
            4: return 64'(($urandom_range(0, 15)));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        rst = 1'b1; in_valid = 1'b0; icode = 4'h1; ifun = 4'h0;
        valA = '0; valB = '0; valC = '0; stall = 1'b0; bubble = 1'b0; set_cc_en = 1'b0;
        @(negedge clk);
        chk("reset_cc", cc, 3'b100);
        chk("reset_out_valid", out_valid, 1'b0);
        chk("reset_out_icode", out_icode, 4'h1);
        chk("reset_valE", valE, 64'h0);
        chk("reset_Cnd", Cnd, 1'b0);

        step(0, 1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 0, 0, 1);
        chk("add_ovf_valE", valE, 64'h8000_0000_0000_0000);
        chk("add_ovf_cc", cc, 3'b011);

        step(0, 1, 4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 0, 0, 1);
        chk("sub_zero_valE", valE, 64'h0);
        chk("sub_zero_cc", cc, 3'b100);
        step(0, 1, 4'h7, 4'h3, 64'h0, 64'h0, 64'h40, 0, 0, 1);
        chk("je_taken_Cnd", Cnd, 1'b1);
        step(0, 1, 4'h7, 4'h4, 64'h0, 64'h0, 64'h40, 0, 0, 1);
        chk("jne_not_taken_Cnd", Cnd, 1'b0);

        step(0, 1, 4'h5, 4'h0, 64'h0, 64'h100, 64'h10, 0, 0, 1);
        chk("mrmov_valE", valE, 64'h110);
        step(0, 1, 4'hA, 4'h0, 64'h0, 64'h200, 64'h0, 0, 0, 1);
        chk("push_valE", valE, 64'h1F8);
        step(0, 1, 4'hB, 4'h0, 64'h0, 64'h1F8, 64'h0, 0, 0, 1);
        chk("pop_valE", valE, 64'h200);
        chk("stack_cc_unchanged", cc, 3'b100);

        step(0, 1, 4'h6, 4'h0, 64'h3, 64'h4, 64'h0, 0, 0, 1);
        chk("opq_before_stall_valE", valE, 64'h7);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 4'h6, 4'h1, 64'h9, 64'h9, 64'h0, 1, 0, 1);
            chk("stall_hold_valE", valE, 64'h7);
            chk("stall_hold_cc", cc, 3'b000);
            chk("stall_hold_out_icode", out_icode, 4'h6);
        end
        step(0, 1, 4'h6, 4'h1, 64'h9, 64'h9, 64'h0, 1, 1, 1);
        chk("bubble_stall_out_valid", out_valid, 1'b0);
        chk("bubble_stall_out_icode", out_icode, 4'h1);
        chk("bubble_stall_cc", cc, 3'b000);

        step(0, 1, 4'h6, 4'h3, 64'hFF, 64'hFF, 64'h0, 0, 0, 0);
        chk("xor_inhibit_valE", valE, 64'h0);
        chk("xor_inhibit_cc", cc, 3'b000);
        step(0, 1, 4'h6, 4'h3, 64'hFF, 64'hFF, 64'h0, 0, 0, 1);
        chk("xor_enabled_cc", cc, 3'b100);

        step(0, 1, 4'h6, 4'h0, 64'h5, 64'h9, 64'h0, 0, 0, 1);
        step(1, 1, 4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 0, 0, 1);
        chk("mid_reset_cc", cc, 3'b100);
        chk("mid_reset_out_valid", out_valid, 1'b0);
        chk("mid_reset_valE", valE, 64'h0);

        for (int n = 0; n < 3000; n++) begin
            logic [3:0] ic;
            ic = ($urandom_range(0, 2) == 0) ? 4'h6 :
                 ($urandom_range(0, 2) == 0) ? 4'h7 : 4'($urandom_range(0, 15));
            step($urandom_range(0, 49) == 0, $urandom_range(0, 9) != 0, ic,
                 4'($urandom_range(0, 15)), pick_val(), pick_val(), pick_val(),
                 $urandom_range(0, 6) == 0, $urandom_range(0, 11) == 0,
                 $urandom_range(0, 7) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
